pixel_stream_writer: RTL and testbench

PIXEL_STREAM_WRITER -- requirements
Module: pixel_stream_writer

---
 rtl/ledcube_pkg.sv | 43 ++++
 rtl/pixel_addr_gen.sv | 68 ++++++
 rtl/pixel_stream_writer.sv | 178 +++++++++++++++++
 tb/tb_pixel_stream_writer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledcube_pkg.sv
// ----------------------------------------------------------------------------
// ledcube_pkg
// Shared geometry and write-port constants for the LED panel chain. The byte
// stream writer and the panel driver both import this package, so the frame
// store layout is defined in one place.
//
// WIDTH / SIZE_BITS below describe the default two-panel chain. Modules that
// take a CHAINED parameter derive their own values through calc_width() and
// calc_size_bits(), so the formulas stay in one place.
// ----------------------------------------------------------------------------
package ledcube_pkg;

    localparam int PANEL_W         = 64;
    localparam int HEIGHT          = 64;
    localparam int DEFAULT_CHAINED = 2;

    // Byte lanes written into the frame store: B, G and R, never the top lane.
    localparam logic [3:0] WR_MASK = 4'b0111;

    function automatic int calc_width(input int chained);
        return PANEL_W * chained;
    endfunction

    function automatic int calc_size_bits(input int chained);
        return $clog2(chained);
    endfunction

    localparam int WIDTH     = calc_width(DEFAULT_CHAINED);
    localparam int SIZE_BITS = calc_size_bits(DEFAULT_CHAINED);

    typedef enum logic [1:0] {
        StIdle,
        StGetR,
        StGetG,
        StGetB
    } wr_state_e;

    // Keep the top 'depth' bits of a colour byte, right-aligned, zero-padded.
    function automatic logic [7:0] trunc_colour(input logic [7:0] b, input int depth);
        return b >> (8 - depth);
    endfunction

endpackage

// File: rtl/pixel_addr_gen.sv
// ----------------------------------------------------------------------------
// pixel_addr_gen
// Raster position counters for the frame store plus the column mapping used
// by serpentine-wired panel chains.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_clear    restart at pixel (0,0) on the next edge
//   i_advance  one pixel has been written; step to the next raster position
//   o_addr     frame-store address of the current position, {y, col}
//   o_last     current position is the final pixel of the frame
// ----------------------------------------------------------------------------
module pixel_addr_gen
    import ledcube_pkg::*;
#(
    parameter int CHAINED    = 2,
    parameter int SERPENTINE = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_advance,
    output logic [15:0] o_addr,
    output logic        o_last
);

    localparam int LINE_W = calc_width(CHAINED);
    localparam int SB     = calc_size_bits(CHAINED);
    localparam int XW     = 6 + SB;

    logic [XW-1:0] r_x;
    logic [5:0]    r_y;
    logic          w_x_last;
    logic [XW-1:0] w_col;

    assign w_x_last = (r_x == XW'(LINE_W - 1));

    // y is six bits wide, so stepping past the bottom row wraps it to 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= r_y + 6'd1;
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    // Serpentine chains feed odd rows from the far end.
    always_comb begin
        w_col = r_x;
        if ((SERPENTINE != 0) && r_y[0]) begin
            w_col = XW'(LINE_W - 1) - r_x;
        end
    end

    assign o_addr = 16'({r_y, w_col});
    assign o_last = w_x_last && (r_y == 6'(HEIGHT - 1));

endmodule

// File: rtl/pixel_stream_writer.sv
// ----------------------------------------------------------------------------
// pixel_stream_writer
// Converts an R,G,B byte stream into 24-bit frame-store writes, one per pixel,
// in raster order. A byte flagged with in_sof restarts the frame at pixel 0.
//
// Ports
//   ctrl_clk, ctrl_rstn   clock (rising edge) and async active-low reset
//   in_valid/in_ready     byte-stream handshake; in_data carries R,G,B bytes
//   in_sof                current byte is the R byte of pixel 0
//   err_clr               clears the sticky error flags
//   ctrl_en/wr/addr/wdat  frame-store write port, one-cycle write strobe
//   frame_done            pulses with the write of the last pixel of a frame
//   frame_cnt             completed frames, wraps at 16 bits
//   err_short             sticky: frame restarted before it was complete
//   err_drop              sticky: byte received while waiting for a frame start
// ----------------------------------------------------------------------------
module pixel_stream_writer
    import ledcube_pkg::*;
#(
    parameter int CHAINED     = 2,
    parameter int INPUT_DEPTH = 6,
    parameter int SERPENTINE  = 0
) (
    input  logic        ctrl_clk,
    input  logic        ctrl_rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    input  logic        err_clr,
    output logic        ctrl_en,
    output logic [3:0]  ctrl_wr,
    output logic [15:0] ctrl_addr,
    output logic [23:0] ctrl_wdat,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        err_short,
    output logic        err_drop
);

    wr_state_e r_state;
    wr_state_e w_state_next;

    logic        w_accept;
    logic        w_load_r;
    logic        w_load_g;
    logic        w_pix_done;
    logic        w_frame_end;
    logic        w_restart;
    logic        w_ev_short;
    logic        w_ev_drop;
    logic [15:0] w_addr;
    logic        w_last;

    logic [7:0]  r_red;
    logic [7:0]  r_green;
    logic        r_ctrl_en;
    logic [3:0]  r_ctrl_wr;
    logic [15:0] r_ctrl_addr;
    logic [23:0] r_ctrl_wdat;
    logic        r_frame_done;
    logic [15:0] r_frame_cnt;
    logic        r_err_short;
    logic        r_err_drop;

    // The stream is never back-pressured; ready only drops while in reset.
    assign in_ready = ctrl_rstn;
    assign w_accept = in_valid && in_ready;

    pixel_addr_gen #(
        .CHAINED    (CHAINED),
        .SERPENTINE (SERPENTINE)
    ) u_addr_gen (
        .i_clk     (ctrl_clk),
        .i_rst_n   (ctrl_rstn),
        .i_clear   (w_restart),
        .i_advance (w_pix_done),
        .o_addr    (w_addr),
        .o_last    (w_last)
    );

    // State register
    always_ff @(posedge ctrl_clk or negedge ctrl_rstn) begin
        if (!ctrl_rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. in_sof always wins: the byte becomes R of pixel 0.
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            if (in_sof) begin
                w_state_next = StGetG;
            end else begin
                unique case (r_state)
                    StIdle: w_state_next = StIdle;
                    StGetR: w_state_next = StGetG;
                    StGetG: w_state_next = StGetB;
                    StGetB: w_state_next = w_last ? StIdle : StGetR;
                endcase
            end
        end
    end

    // Per-cycle events decoded from the state and the accepted byte.
    always_comb begin
        w_restart   = w_accept && in_sof;
        w_load_r    = w_accept && (in_sof || (r_state == StGetR));
        w_load_g    = w_accept && !in_sof && (r_state == StGetG);
        w_pix_done  = w_accept && !in_sof && (r_state == StGetB);
        w_frame_end = w_pix_done && w_last;
        w_ev_short  = w_accept && in_sof && (r_state != StIdle);
        w_ev_drop   = w_accept && !in_sof && (r_state == StIdle);
    end

    always_ff @(posedge ctrl_clk or negedge ctrl_rstn) begin
        if (!ctrl_rstn) begin
            r_red   <= '0;
            r_green <= '0;
        end else begin
            if (w_load_r) begin
                r_red <= in_data;
            end
            if (w_load_g) begin
                r_green <= in_data;
            end
        end
    end

    // Write port: the B byte goes straight from in_data into the write word.
    always_ff @(posedge ctrl_clk or negedge ctrl_rstn) begin
        if (!ctrl_rstn) begin
            r_ctrl_en   <= 1'b0;
            r_ctrl_wr   <= '0;
            r_ctrl_addr <= '0;
            r_ctrl_wdat <= '0;
        end else begin
            r_ctrl_en <= w_pix_done;
            r_ctrl_wr <= w_pix_done ? WR_MASK : 4'b0000;
            if (w_pix_done) begin
                r_ctrl_addr <= w_addr;
                r_ctrl_wdat <= {trunc_colour(r_red, INPUT_DEPTH),
                                trunc_colour(r_green, INPUT_DEPTH),
                                trunc_colour(in_data, INPUT_DEPTH)};
            end
        end
    end

    // Status. A new error in the clearing cycle must still leave the flag set.
    always_ff @(posedge ctrl_clk or negedge ctrl_rstn) begin
        if (!ctrl_rstn) begin
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
            r_err_short  <= 1'b0;
            r_err_drop   <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            r_err_short <= (r_err_short && !err_clr) || w_ev_short;
            r_err_drop  <= (r_err_drop && !err_clr) || w_ev_drop;
        end
    end

    assign ctrl_en    = r_ctrl_en;
    assign ctrl_wr    = r_ctrl_wr;
    assign ctrl_addr  = r_ctrl_addr;
    assign ctrl_wdat  = r_ctrl_wdat;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;
    assign err_short  = r_err_short;
    assign err_drop   = r_err_drop;

endmodule

// File: tb/tb_pixel_stream_writer.sv
// ----------------------------------------------------------------------------
// tb_pixel_stream_writer
// Drives one random-gapped byte stream into two writers (linear and serpentine
// column order) and compares every cycle against a pixel-index based model.
// ----------------------------------------------------------------------------
module tb_pixel_stream_writer;

    localparam int CHAINED   = 2;
    localparam int DEPTH     = 6;
    localparam int LINE_W    = 64 * CHAINED;
    localparam int FRAME_PIX = LINE_W * 64;

    logic        ctrl_clk  = 1'b0;
    logic        ctrl_rstn = 1'b0;
    logic        in_valid  = 1'b0;
    logic [7:0]  in_data   = 8'h00;
    logic        in_sof    = 1'b0;
    logic        err_clr   = 1'b0;

    logic        a_ready, b_ready;
    logic        a_en, b_en;
    logic [3:0]  a_wr, b_wr;
    logic [15:0] a_addr, b_addr;
    logic [23:0] a_wdat, b_wdat;
    logic        a_done, b_done;
    logic [15:0] a_cnt, b_cnt;
    logic        a_short, b_short;
    logic        a_drop, b_drop;

    pixel_stream_writer #(
        .CHAINED     (CHAINED),
        .INPUT_DEPTH (DEPTH),
        .SERPENTINE  (0)
    ) u_dut_lin (
        .ctrl_clk   (ctrl_clk),
        .ctrl_rstn  (ctrl_rstn),
        .in_valid   (in_valid),
        .in_ready   (a_ready),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .err_clr    (err_clr),
        .ctrl_en    (a_en),
        .ctrl_wr    (a_wr),
        .ctrl_addr  (a_addr),
        .ctrl_wdat  (a_wdat),
        .frame_done (a_done),
        .frame_cnt  (a_cnt),
        .err_short  (a_short),
        .err_drop   (a_drop)
    );

    pixel_stream_writer #(
        .CHAINED     (CHAINED),
        .INPUT_DEPTH (DEPTH),
        .SERPENTINE  (1)
    ) u_dut_serp (
        .ctrl_clk   (ctrl_clk),
        .ctrl_rstn  (ctrl_rstn),
        .in_valid   (in_valid),
        .in_ready   (b_ready),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .err_clr    (err_clr),
        .ctrl_en    (b_en),
        .ctrl_wr    (b_wr),
        .ctrl_addr  (b_addr),
        .ctrl_wdat  (b_wdat),
        .frame_done (b_done),
        .frame_cnt  (b_cnt),
        .err_short  (b_short),
        .err_drop   (b_drop)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    int num_checks = 0;
    int num_fail   = 0;
    int max_idle   = 2;

    // Reference model state
    bit         m_in_frame = 1'b0;
    logic [7:0] m_bytes[$];
    int         m_pix      = 0;
    int         m_frames   = 0;
    bit         m_short    = 1'b0;
    bit         m_drop     = 1'b0;
    bit         exp_en     = 1'b0;
    bit         exp_done   = 1'b0;
    logic [15:0] exp_addr_lin  = '0;
    logic [15:0] exp_addr_serp = '0;
    logic [23:0] exp_wdat      = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] scale(input logic [7:0] b);
        return 8'(int'(b) / (2 ** (8 - DEPTH)));
    endfunction

    function automatic logic [15:0] map_addr(input int p, input bit serp);
        int x, y, col;
        x   = p % LINE_W;
        y   = p / LINE_W;
        col = (serp && (y % 2 == 1)) ? (LINE_W - 1 - x) : x;
        return 16'(y * LINE_W + col);
    endfunction

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_bytes.delete();
        m_pix    = 0;
        m_frames = 0;
        m_short  = 1'b0;
        m_drop   = 1'b0;
        exp_en   = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic model_cycle(input bit acc, input logic [7:0] d, input bit sof, input bit clr);
        bit ev_short;
        bit ev_drop;
        ev_short = 1'b0;
        ev_drop  = 1'b0;
        exp_en   = 1'b0;
        exp_done = 1'b0;
        if (acc) begin
            if (sof) begin
                if (m_in_frame) ev_short = 1'b1;
                m_in_frame = 1'b1;
                m_pix      = 0;
                m_bytes.delete();
                m_bytes.push_back(d);
            end else if (!m_in_frame) begin
                ev_drop = 1'b1;
            end else begin
                m_bytes.push_back(d);
                if (m_bytes.size() == 3) begin
                    exp_en        = 1'b1;
                    exp_addr_lin  = map_addr(m_pix, 1'b0);
                    exp_addr_serp = map_addr(m_pix, 1'b1);
                    exp_wdat      = {scale(m_bytes[0]), scale(m_bytes[1]), scale(m_bytes[2])};
                    if (m_pix == FRAME_PIX - 1) begin
                        exp_done   = 1'b1;
                        m_frames   = m_frames + 1;
                        m_in_frame = 1'b0;
                    end
                    m_pix = m_pix + 1;
                    m_bytes.delete();
                end
            end
        end
        m_short = (clr ? 1'b0 : m_short) | ev_short;
        m_drop  = (clr ? 1'b0 : m_drop) | ev_drop;
    endtask

    task automatic check_outputs();
        check_eq("lin_ready", a_ready, 1);
        check_eq("serp_ready", b_ready, 1);
        check_eq("lin_en", a_en, exp_en);
        check_eq("serp_en", b_en, exp_en);
        check_eq("lin_wr", a_wr, exp_en ? 4'h7 : 4'h0);
        check_eq("serp_wr", b_wr, exp_en ? 4'h7 : 4'h0);
        check_eq("lin_done", a_done, exp_done);
        check_eq("serp_done", b_done, exp_done);
        check_eq("lin_cnt", a_cnt, 16'(m_frames));
        check_eq("serp_cnt", b_cnt, 16'(m_frames));
        check_eq("lin_short", a_short, m_short);
        check_eq("serp_short", b_short, m_short);
        check_eq("lin_drop", a_drop, m_drop);
        check_eq("serp_drop", b_drop, m_drop);
        if (exp_en) begin
            check_eq("lin_addr", a_addr, exp_addr_lin);
            check_eq("serp_addr", b_addr, exp_addr_serp);
            check_eq("lin_wdat", a_wdat, exp_wdat);
            check_eq("serp_wdat", b_wdat, exp_wdat);
        end
    endtask

    // One clock: inputs applied now, outputs checked 1 time unit after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit sof, input bit clr);
        in_valid = v;
        in_data  = d;
        in_sof   = sof;
        err_clr  = clr;
        @(posedge ctrl_clk);
        #1;
        model_cycle(v, d, sof, clr);
        check_outputs();
    endtask

    // Random idle gaps carry junk data and sof to prove in_valid gates them.
    task automatic send_byte(input logic [7:0] d, input bit sof);
        int gaps;
        gaps = $urandom_range(0, max_idle);
        for (int i = 0; i < gaps; i++) begin
            step(1'b0, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        step(1'b1, d, sof, 1'b0);
    endtask

    task automatic send_pixel(input bit sof, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b);
        send_byte(r, sof);
        send_byte(g, 1'b0);
        send_byte(b, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, a_ready, 0);
        check_eq({tag, "_en"}, a_en, 0);
        check_eq({tag, "_wr"}, a_wr, 0);
        check_eq({tag, "_addr"}, a_addr, 0);
        check_eq({tag, "_wdat"}, a_wdat, 0);
        check_eq({tag, "_done"}, a_done, 0);
        check_eq({tag, "_cnt"}, a_cnt, 0);
        check_eq({tag, "_short"}, a_short, 0);
        check_eq({tag, "_drop"}, a_drop, 0);
        check_eq({tag, "_serp_en"}, b_en, 0);
        check_eq({tag, "_serp_addr"}, b_addr, 0);
        check_eq({tag, "_serp_cnt"}, b_cnt, 0);
    endtask

    // Reset asserts between clock edges; outputs must clear without a clock.
    task automatic apply_reset(input string tag);
        #2;
        ctrl_rstn = 1'b0;
        in_valid  = 1'b0;
        err_clr   = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        @(posedge ctrl_clk);
        @(negedge ctrl_clk);
        ctrl_rstn = 1'b1;
        @(posedge ctrl_clk);
        #1;
        model_cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_outputs();
    endtask

    initial begin
        logic [7:0] r, g, b;

        apply_reset("rst0");

        // Bytes without a frame start are dropped.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
        check_eq("drop_after_reset", a_drop, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("drop_cleared", a_drop, 0);

        // First pixel with known colours.
        send_pixel(1'b1, 8'hFC, 8'h80, 8'h04);
        check_eq("first_en", a_en, 1);
        check_eq("first_wr", a_wr, 4'h7);
        check_eq("first_addr", a_addr, 16'h0000);
        check_eq("first_wdat", a_wdat, 24'h3F2001);

        // Frame restarted in the middle of pixel 5.
        apply_reset("rst1");
        send_pixel(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        for (int p = 1; p < 5; p++) send_pixel(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
        check_eq("pix4_addr", a_addr, 16'h0004);
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);
        send_pixel(1'b1, 8'h40, 8'h20, 8'h10);
        check_eq("short_set", a_short, 1);
        check_eq("restart_addr", a_addr, 16'h0000);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("short_cleared", a_short, 0);

        // Full frame with randomly gapped valid.
        apply_reset("rst2");
        max_idle = 1;
        for (int p = 0; p < FRAME_PIX; p++) begin
            r = 8'($urandom);
            g = 8'($urandom);
            b = 8'($urandom);
            send_pixel(p == 0, r, g, b);
            if (p == 128) begin
                check_eq("pix128_lin_addr", a_addr, 16'h0080);
                check_eq("pix128_serp_addr", b_addr, 16'h00FF);
            end
        end
        check_eq("last_addr", a_addr, 16'h1FFF);
        check_eq("last_done", a_done, 1);
        check_eq("frame_cnt_one", a_cnt, 16'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("done_one_cycle", a_done, 0);

        // Bytes after the frame ended are dropped again.
        max_idle = 2;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
        check_eq("drop_after_frame", a_drop, 1);

        // Reset between G and B: nothing written, counters cleared.
        send_pixel(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        send_byte(8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);
        apply_reset("rst_mid");
        send_byte(8'($urandom), 1'b0);
        check_eq("no_write_after_rst", a_en, 0);
        check_eq("drop_after_rst_mid", a_drop, 1);
        check_eq("cnt_after_rst_mid", a_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
        $finish;
    end

endmodule
